// File: rtl/active_list_commit.sv
// active_list_commit
//   In-order retirement buffer (active list) feeding the physical register
//   file write port and the free list. Dispatch allocates entries at the
//   tail, execution write-back marks entries done, and the head entry
//   retires in program order once it is done.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 discard every in-flight entry
//   alloc_*               dispatch allocation request / payload, alloc_ready,
//                         alloc_tag (index given to the current allocation)
//   wb_valid/tag/data     execution write-back
//   commit_reg_*          registered register-file write (one-cycle pulse)
//   commit_free_*         registered release of the old physical register
//   count                 occupied entries
//
// Optional feature (define ACTIVE_LIST_PERF_CNT_EN):
//   adds perf_commits and perf_full_cycles 32-bit counters.
module active_list_commit #(
    parameter int DEPTH       = 16,
    parameter int PHYS_ADDR_W = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_W       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic                   alloc_dst_valid,
    input  logic [PHYS_ADDR_W-1:0] alloc_phys_dst,
    input  logic [PHYS_ADDR_W-1:0] alloc_old_phys,
    output logic [TAG_W-1:0]       alloc_tag,
    input  logic                   wb_valid,
    input  logic [TAG_W-1:0]       wb_tag,
    input  logic [DATA_WIDTH-1:0]  wb_data,
    output logic                   commit_reg_wr_en,
    output logic [PHYS_ADDR_W-1:0] commit_reg_addr,
    output logic [DATA_WIDTH-1:0]  commit_result_data,
    output logic                   commit_free_valid,
    output logic [PHYS_ADDR_W-1:0] commit_free_phys,
    output logic [TAG_W:0]         count
`ifdef ACTIVE_LIST_PERF_CNT_EN
    ,
    output logic [31:0]            perf_commits,
    output logic [31:0]            perf_full_cycles
`endif
);

    localparam logic [TAG_W:0] PTR_ONE = 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]   head;
    logic [TAG_W:0]   tail;
    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_done;

    // Payload storage: only meaningful while the matching valid bit is set.
    logic [DEPTH-1:0]       ent_dst_valid;
    logic [PHYS_ADDR_W-1:0] ent_phys_dst [DEPTH];
    logic [PHYS_ADDR_W-1:0] ent_old_phys [DEPTH];
    logic [DATA_WIDTH-1:0]  ent_data     [DEPTH];

    logic full;
    logic alloc_fire;
    logic wb_fire;
    logic retire_p0;

    assign head_idx    = head[TAG_W-1:0];
    assign tail_idx    = tail[TAG_W-1:0];
    assign full        = (head[TAG_W] != tail[TAG_W]) && (head_idx == tail_idx);
    assign count       = tail - head;
    // Readiness comes only from registered pointers, so a full list stays
    // not-ready in the very cycle its head retires.
    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;

    assign alloc_fire = alloc_valid && !full && !flush;
    assign wb_fire    = wb_valid && ent_valid[wb_tag] && !flush;
    // Decision uses registered done only: a same-cycle write-back to the
    // head does not retire it until the next cycle.
    assign retire_p0  = ent_valid[head_idx] && ent_done[head_idx] && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            if (wb_fire) begin
                ent_done[wb_tag] <= 1'b1;
            end
            if (retire_p0) begin
                ent_valid[head_idx] <= 1'b0;
                head                <= head + PTR_ONE;
            end
            // An allocating slot is never valid, so it cannot collide with
            // an accepted write-back in the same cycle.
            if (alloc_fire) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_done[tail_idx]  <= 1'b0;
                tail                <= tail + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_dst_valid[tail_idx] <= alloc_dst_valid;
            ent_phys_dst[tail_idx]  <= alloc_phys_dst;
            ent_old_phys[tail_idx]  <= alloc_old_phys;
        end
        if (wb_fire) begin
            ent_data[wb_tag] <= wb_data;
        end
    end

    // ---- stage p1: registered commit outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_reg_wr_en   <= 1'b0;
            commit_reg_addr    <= '0;
            commit_result_data <= '0;
            commit_free_valid  <= 1'b0;
            commit_free_phys   <= '0;
        end else if (retire_p0) begin
            commit_reg_wr_en  <= ent_dst_valid[head_idx];
            commit_free_valid <= ent_dst_valid[head_idx];
            // Address/data only move when a real register write happens.
            if (ent_dst_valid[head_idx]) begin
                commit_reg_addr    <= ent_phys_dst[head_idx];
                commit_result_data <= ent_data[head_idx];
                commit_free_phys   <= ent_old_phys[head_idx];
            end
        end else begin
            commit_reg_wr_en  <= 1'b0;
            commit_free_valid <= 1'b0;
        end
    end

`ifdef ACTIVE_LIST_PERF_CNT_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_commits     <= '0;
            perf_full_cycles <= '0;
        end else begin
            if (retire_p0) begin
                perf_commits <= perf_commits + 32'd1;
            end
            if (full) begin
                perf_full_cycles <= perf_full_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/active_list_commit.md
Name: active_list_commit

Overview:
- In-order retirement buffer (active list) sitting directly upstream of the physical register file's write port.
- Dispatch allocates one entry per instruction in program order; execution write-back marks entries done and deposits result data.
- The head entry retires in order, producing the register-file write (Reg_WR_EN, reg_addr, result_data) and the freed old physical register for the free list.
- A flush input discards all in-flight entries on mispredict or exception.

Parameters:
DEPTH, 16, number of entries; power of two, at least 2
PHYS_ADDR_W, 6, physical register address width (64 physical registers)
DATA_WIDTH, 32, result data width
TAG_W, $clog2(DEPTH), entry index width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  discard all entries
alloc_valid  input  1  dispatch requests an entry
alloc_ready  output  1  entry available (count < DEPTH)
alloc_dst_valid  input  1  instruction writes a destination register
alloc_phys_dst  input  PHYS_ADDR_W  newly mapped physical destination
alloc_old_phys  input  PHYS_ADDR_W  previous mapping, freed at commit
alloc_tag  output  TAG_W  index assigned to the current allocation (= tail)
wb_valid  input  1  execution result valid
wb_tag  input  TAG_W  entry being completed
wb_data  input  DATA_WIDTH  result value
commit_reg_wr_en  output  1  register-file write enable (Reg_WR_EN)
commit_reg_addr  output  PHYS_ADDR_W  register-file write address
commit_result_data  output  DATA_WIDTH  register-file write data
commit_free_valid  output  1  old physical register released
commit_free_phys  output  PHYS_ADDR_W  released register
count  output  TAG_W+1  occupied entries

Behaviour:
- Reset value of every output and all state is 0: head/tail pointers, count, per-entry valid/done, every commit_* output. After reset alloc_ready=1.
- Storage is a circular buffer. head and tail are TAG_W+1 bits with a wrap bit. Full when the low bits are equal and the wrap bits differ; empty when head==tail. count = tail-head, modulo 2^(TAG_W+1).
- Allocate fires on alloc_valid && alloc_ready:
  - entry[tail] gets valid=1, done=0, dst_valid, phys_dst, old_phys.
  - tail increments.
  - alloc_tag is combinational, equal to tail[TAG_W-1:0].
- alloc_ready depends only on registered count, never combinationally on a same-cycle commit. A full buffer stays not-ready for the cycle in which the head retires.
- Write-back on wb_valid sets entry[wb_tag].done=1 and stores wb_data.
  - Write-back to an entry with valid=0 is ignored.
  - Write-back to an already-done entry overwrites the data.
- Commit decision is made each cycle: retire iff entry[head].valid && entry[head].done, as registered state, and no flush.
  - Retire clears entry[head].valid and increments head. At most one retire per cycle.
- Commit outputs are registered and pulse for exactly one cycle after the retire edge:
  - commit_reg_wr_en = dst_valid; commit_reg_addr = phys_dst; commit_result_data = stored data.
  - commit_free_valid = dst_valid; commit_free_phys = old_phys.
  - When an entry with dst_valid=0 retires, both enables are 0.
  - In cycles with no retire, both enables are 0. Address and data hold their last values.
- Latency: write-back at edge N sets done; the retire decision happens in the cycle after edge N; commit outputs are valid in the cycle after edge N+1. Minimum write-back-to-Reg_WR_EN latency is 2 cycles.
- Same-cycle write-back to the head entry does not retire it that cycle; there is no bypass.
- Simultaneous allocate and retire: both proceed, count unchanged.
- Wrap-around: pointers wrap modulo DEPTH and the wrap bit toggles. Entry DEPTH-1 is followed by entry 0.
- Flush takes priority over allocate, write-back and retire in the same cycle:
  - all valid bits cleared; head=tail=0; count=0.
  - commit enables are 0 on the next cycle.
  - the register file and free list are not written for flushed entries.
- rst_n asserted mid-operation clears everything immediately (asynchronously), including in-flight commit pulses.

Optional Feature:
ACTIVE_LIST_PERF_CNT_EN
- Defined: adds outputs perf_commits (32 bits) and perf_full_cycles (32 bits).
  - perf_commits increments on every retire.
  - perf_full_cycles increments on every cycle where count==DEPTH.
  - Both reset to 0, are not cleared by flush, and wrap at 2^32.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then allocate 1 entry (dst_valid=1, phys_dst=5, old_phys=9) at tag 0, then write back tag 0 with 0xDEADBEEF -> 2 cycles after write-back: commit_reg_wr_en=1, addr=5, data=0xDEADBEEF, free_valid=1, free_phys=9 for exactly 1 cycle; count returns to 0.
- Allocate tags 0,1,2; write back in order 2,1,0 -> no commit until tag 0 is done; then 3 consecutive single-cycle commits in order 0,1,2.
- Allocate 16 entries -> alloc_ready=0, count=16; a 17th alloc_valid is ignored. Complete and retire the head; on the following cycle alloc_ready=1 and the next alloc_tag=0 (wrap-around).
- Allocate with dst_valid=0 and complete it -> the entry retires with commit_reg_wr_en=0 and commit_free_valid=0; head advances.
- Allocate 4 entries, complete 2, assert flush in the same cycle as an alloc and a write-back -> count=0 next cycle, no commit pulses, next alloc_tag=0.
- Pulse rst_n low mid-stream with a commit pending -> all outputs 0 immediately; after release alloc_ready=1 and count=0.
